pc_sequencer: RTL and testbench

Parametrised program-counter unit for the 8-bit processor datapath, successor to the plain load-on-write PC register. Each enabled clock edge it advances, jumps or branches the program counter, or performs a call/return through an internal hardware return-address stack. It sits between the control unit (which drives `PCOp` and `PCWrite`) and instruction memory (which is addressed by `PCOut`).

---
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_sequencer.sv | 111 +++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Control-unit to PC-sequencer bus: operation request in, PC and stack status out.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic             PCWrite;
    logic [2:0]       PCOp;
    logic [WIDTH-1:0] PCIn;
    logic [WIDTH-1:0] Offset;
    logic [WIDTH-1:0] PCOut;
    logic [DW-1:0]    StackDepth;
    logic             StackEmpty;
    logic             StackFull;
    logic             Fault;

    modport master (
        output PCWrite, PCOp, PCIn, Offset,
        input  PCOut, StackDepth, StackEmpty, StackFull, Fault
    );

    modport slave (
        input  PCWrite, PCOp, PCIn, Offset,
        output PCOut, StackDepth, StackEmpty, StackFull, Fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter unit: INC/JMP/BR plus CALL/RET through a small return-address stack.
// Overflow/underflow hold PC and depth and set a sticky Fault.
module pc_sequencer #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned INC_STEP     = 1
) (
    input  logic Clock,
    input  logic Reset,
    pc_sequencer_if.slave bus
);
    localparam int unsigned DW = $clog2(DEPTH + 1);

    localparam logic [2:0] OP_INC  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BR   = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             fault_q, fault_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] top;
    logic             push;

    assign pc_inc = pc_q + WIDTH'(INC_STEP);

    // Top-of-stack lives one below the current depth.
    always_comb begin
        top = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (depth_q == DW'(i + 1)) top = stack_q[i];
        end
    end

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        fault_d = fault_q;
        push    = 1'b0;
        if (bus.PCWrite) begin
            case (bus.PCOp)
                OP_INC: pc_d = pc_inc;
                OP_JMP: pc_d = bus.PCIn;
                OP_BR:  pc_d = pc_q + bus.Offset;
                OP_CALL: begin
                    if (full_q) begin
                        fault_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        pc_d    = bus.PCIn;
                        depth_d = depth_q + DW'(1);
                    end
                end
                OP_RET: begin
                    if (empty_q) begin
                        fault_d = 1'b1;
                    end else begin
                        pc_d    = top;
                        depth_d = depth_q - DW'(1);
                    end
                end
                default: ;
            endcase
        end
        empty_d = (depth_d == '0);
        full_d  = (depth_d == DW'(DEPTH));
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            stack_d[i] = (push && depth_q == DW'(i)) ? pc_inc : stack_q[i];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_q    <= WIDTH'(RESET_VECTOR);
            depth_q <= '0;
            fault_q <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            fault_q <= fault_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    // Stack entries are deliberately not reset; depth alone marks validity.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            stack_q[i] <= stack_d[i];
        end
    end

    assign bus.PCOut      = pc_q;
    assign bus.StackDepth = depth_q;
    assign bus.StackEmpty = empty_q;
    assign bus.StackFull  = full_q;
    assign bus.Fault      = fault_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, async-reset corners, and random ops vs a queue model.
module tb_pc_sequencer;
    localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3, RET = 3'd4, NOP = 3'd5;

    typedef struct {
        bit         we;
        logic [2:0] op;
        logic [7:0] pin;
        logic [7:0] off;
        logic [7:0] exp_pc;
        int         exp_depth;
        bit         exp_fault;
    } vec_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    pc_sequencer_if #(.WIDTH(8), .DEPTH(4)) bus ();

    pc_sequencer #(.WIDTH(8), .DEPTH(4), .RESET_VECTOR(0), .INC_STEP(1)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    int total_cnt = 0;
    int pass_cnt  = 0;

    int m_pc;
    int m_stk[$];
    bit m_fault;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_fault = 1'b0;
    endtask

    task automatic model_step(input bit we, input logic [2:0] op, input int pin, input int off);
        if (!we) return;
        case (op)
            INC: m_pc = (m_pc + 1) % 256;
            JMP: m_pc = pin;
            BR:  m_pc = (m_pc + off) % 256;
            CALL: begin
                if (m_stk.size() == 4) m_fault = 1'b1;
                else begin
                    m_stk.push_back((m_pc + 1) % 256);
                    m_pc = pin;
                end
            end
            RET: begin
                if (m_stk.size() == 0) m_fault = 1'b1;
                else m_pc = m_stk.pop_back();
            end
            default: ;
        endcase
    endtask

    task automatic step(input bit we, input logic [2:0] op, input logic [7:0] pin, input logic [7:0] off);
        bus.PCWrite = we;
        bus.PCOp    = op;
        bus.PCIn    = pin;
        bus.Offset  = off;
        @(posedge Clock);
        #1;
        model_step(we, op, int'(pin), int'(off));
    endtask

    task automatic chk_state(input string tag, input int pc, input int depth, input bit fault);
        chk({tag, ".pc"},    int'(bus.PCOut), pc);
        chk({tag, ".depth"}, int'(bus.StackDepth), depth);
        chk({tag, ".empty"}, int'(bus.StackEmpty), int'(depth == 0));
        chk({tag, ".full"},  int'(bus.StackFull), int'(depth == 4));
        chk({tag, ".fault"}, int'(bus.Fault), int'(fault));
    endtask

    function automatic vec_t v(input bit we, input logic [2:0] op, input logic [7:0] pin,
                               input logic [7:0] off, input logic [7:0] pc, input int d, input bit f);
        vec_t r;
        r.we = we; r.op = op; r.pin = pin; r.off = off;
        r.exp_pc = pc; r.exp_depth = d; r.exp_fault = f;
        return r;
    endfunction

    initial begin
        bus.PCWrite = 1'b1;
        bus.PCOp    = JMP;
        bus.PCIn    = 8'h55;
        bus.Offset  = 8'h00;
        model_reset();

        // Ops presented while Reset is high must be ignored across an edge.
        #12;
        chk_state("reset", 0, 0, 1'b0);
        bus.PCWrite = 1'b0;
        Reset = 1'b0;

        for (int i = 0; i < 256; i++) begin
            step(1'b1, INC, 8'h00, 8'h00);
            chk("inc.pc", int'(bus.PCOut), (i + 1) % 256);
        end
        chk_state("inc_wrap", 0, 0, 1'b0);

        for (int i = 0; i < 32; i++) begin
            step(1'b0, JMP, 8'h40, 8'h00);
            chk("stall.pc", int'(bus.PCOut), 0);
        end
        for (int i = 0; i < 32; i++) begin
            step(1'b1, JMP, 8'h40, 8'h00);
            chk("jmp.pc", int'(bus.PCOut), 'h40);
        end

        tbl.push_back(v(1, JMP,  8'h10, 8'h00, 8'h10, 0, 0));
        tbl.push_back(v(1, BR,   8'h00, 8'hFC, 8'h0C, 0, 0));
        tbl.push_back(v(1, BR,   8'h00, 8'h05, 8'h11, 0, 0));
        tbl.push_back(v(1, JMP,  8'hFE, 8'h00, 8'hFE, 0, 0));
        tbl.push_back(v(1, BR,   8'h00, 8'h03, 8'h01, 0, 0));
        tbl.push_back(v(1, JMP,  8'h20, 8'h00, 8'h20, 0, 0));
        tbl.push_back(v(1, CALL, 8'h80, 8'h00, 8'h80, 1, 0));
        tbl.push_back(v(1, CALL, 8'h90, 8'h00, 8'h90, 2, 0));
        tbl.push_back(v(1, CALL, 8'hA0, 8'h00, 8'hA0, 3, 0));
        tbl.push_back(v(1, RET,  8'h00, 8'h00, 8'h91, 2, 0));
        tbl.push_back(v(1, RET,  8'h00, 8'h00, 8'h81, 1, 0));
        tbl.push_back(v(1, RET,  8'h00, 8'h00, 8'h21, 0, 0));
        tbl.push_back(v(1, NOP,  8'h77, 8'h11, 8'h21, 0, 0));
        tbl.push_back(v(0, CALL, 8'h55, 8'h00, 8'h21, 0, 0));
        tbl.push_back(v(1, CALL, 8'h30, 8'h00, 8'h30, 1, 0));
        tbl.push_back(v(1, CALL, 8'h31, 8'h00, 8'h31, 2, 0));
        tbl.push_back(v(1, CALL, 8'h32, 8'h00, 8'h32, 3, 0));
        tbl.push_back(v(1, CALL, 8'h33, 8'h00, 8'h33, 4, 0));
        tbl.push_back(v(1, CALL, 8'h34, 8'h00, 8'h33, 4, 1));
        tbl.push_back(v(0, RET,  8'h00, 8'h00, 8'h33, 4, 1));
        tbl.push_back(v(1, RET,  8'h00, 8'h00, 8'h33, 3, 1));
        tbl.push_back(v(1, RET,  8'h00, 8'h00, 8'h32, 2, 1));
        tbl.push_back(v(1, RET,  8'h00, 8'h00, 8'h31, 1, 1));
        tbl.push_back(v(1, RET,  8'h00, 8'h00, 8'h22, 0, 1));
        tbl.push_back(v(1, RET,  8'h00, 8'h00, 8'h22, 0, 1));
        tbl.push_back(v(1, INC,  8'h00, 8'h00, 8'h23, 0, 1));

        foreach (tbl[i]) begin
            step(tbl[i].we, tbl[i].op, tbl[i].pin, tbl[i].off);
            chk_state($sformatf("vec%0d", i), int'(tbl[i].exp_pc), tbl[i].exp_depth, tbl[i].exp_fault);
        end

        // Async reset between edges, taking effect before the next edge.
        #3;
        Reset = 1'b1;
        #1;
        chk_state("async_rst1", 0, 0, 1'b0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_reset();

        step(1'b1, CALL, 8'h70, 8'h00);
        step(1'b1, CALL, 8'h71, 8'h00);
        chk_state("two_calls", 'h71, 2, 1'b0);
        #3;
        Reset = 1'b1;
        #1;
        chk_state("async_rst2", 0, 0, 1'b0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_reset();
        step(1'b1, RET, 8'h00, 8'h00);
        chk_state("ret_after_rst", 0, 0, 1'b1);

        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            int unsigned r;
            logic [2:0] op;
            r  = $urandom_range(0, 9);
            op = (r < 3) ? CALL : (r < 6) ? RET : 3'($urandom_range(0, 7));
            step($urandom_range(0, 4) != 0, op, 8'($urandom), 8'($urandom));
            chk_state("rand", m_pc, m_stk.size(), m_fault);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
